board_loader: RTL and testbench
===============================

Name: board_loader

Overview:
- Writer side of the 256-bit Game of Life board bus. Assembles a full 16x16 board from a byte stream (host or UART deframer) and presents it as a parallel board for the generation engine's input_board.
- Double-buffered: a shadow register accumulates the incoming bytes. The visible board changes only on a complete frame, so the engine never sees a partial board.

Parameters:
- CELLS, 256, total cells per board (GRID_DIM*GRID_DIM); must be a multiple of BYTE_W.
- BYTE_W, 8, cells carried per stream word.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  BYTE_W  8 cells; in_data[0] is the lowest-indexed cell of the byte.
- in_valid  input  1  in_data/in_sof valid this cycle.
- in_sof  input  1  marks the first byte of a frame; qualified by in_valid.
- in_ready  output  1  loader accepts the byte this cycle.
- hold  input  1  freeze request (engine mid-update); stalls input.
- board  output  CELLS  last complete board; cell index = row*16 + col.
- board_valid  output  1  one-cycle pulse when board is updated.
- busy  output  1  a frame is partially loaded.
- frame_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Accept = in_valid && in_ready. in_ready = !reset && !hold && state != COMMIT (combinational from registered state).
- Data and in_sof may be held across stalls; only an accept advances state.
- Mapping: byte k (0..NUM_BYTES-1, NUM_BYTES = CELLS/BYTE_W = 32) goes to shadow[BYTE_W*k +: BYTE_W]. Two bytes per row; byte 2r is cols 0-7 of row r.
- Byte counter cnt is $clog2(NUM_BYTES) bits wide and counts 0..31.
- States:
  - IDLE (cnt=0):
    - Accept with in_sof: write byte 0, cnt=1, go to LOAD.
    - Accept without in_sof: byte dropped, frame_err pulse, stay in IDLE.
  - LOAD:
    - Accept without in_sof: write byte cnt, cnt+1.
    - Accept of byte NUM_BYTES-1: same edge loads board <= {in_data, shadow[lower bits]}, cnt=0, go to COMMIT.
    - Accept with in_sof mid-frame: frame_err pulse, discard partial frame, treat the byte as byte 0 (cnt=1), stay in LOAD.
  - COMMIT: one cycle. board_valid=1 (registered, so it is visible the cycle after the last accept edge); in_ready=0; next state IDLE.
- Latency: last byte accepted at edge N; board and board_valid are valid in the cycle after edge N; a new frame can be accepted from edge N+2.
- Shadow bits not yet rewritten keep stale data. This is harmless because board only loads on a complete frame.
- hold: affects only in_ready. A frame in progress stays in LOAD with cnt preserved. hold does not block the COMMIT cycle.
- busy = (state == LOAD).
- frame_err and board_valid are registered single-cycle pulses, never asserted together by the same byte except as specified above.
- Reset (synchronous; wins over every other event in the same cycle):
  - board = 0, board_valid = 0, frame_err = 0, busy = 0, shadow = 0, cnt = 0, state = IDLE; in_ready is 0 while reset is high.
  - Reset mid-frame discards the partial frame; the next frame must start with in_sof.
- Single-byte frames are impossible, since NUM_BYTES >= 2 is required. Elaboration check: CELLS % BYTE_W == 0 and NUM_BYTES >= 2.

Decomposition:
- Shared package life_pkg:
  - GRID_DIM = 16, CELLS = 256, BYTE_W = 8, NUM_BYTES = 32.
  - Loader state enum {IDLE, LOAD, COMMIT}.
  - Board width typedef, shared with the generation engine.
- No sub-module needed. The FSM, counter and shadow register sit in one module.

Test Plan:
- Reset, then stream 32 bytes with in_sof on byte 0, values byte k = k, no gaps -> board_valid pulses exactly once, one cycle after the byte-31 accept; board[15:8] = 8'h01 and board[255:248] = 8'h1F; in_ready low for exactly that one COMMIT cycle.
- Glider frame: bytes 0/2/4 = 8'h02/8'h04/8'h07, rest 0, with random in_valid gaps -> board bits 1, 18, 32, 33, 34 set and all others clear; busy high from the first accept through the last.
- Byte 10 of a frame carries in_sof -> frame_err single pulse; that byte becomes byte 0; a board_valid pulse occurs only after 31 further bytes, and board holds the new frame only.
- Bytes without in_sof while in IDLE -> each accepted, one frame_err pulse per byte, board unchanged, busy stays 0.
- hold asserted for 5 cycles after byte 20 -> in_ready=0 during hold with no accepts; after release the frame completes at byte 31 with correct contents.
- Reset asserted after byte 15 of frame A, then a full frame B -> board = 0 until B completes, then equals B exactly; no board_valid pulse for A.

Source files
------------

// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared Game of Life board geometry, board type and loader states
//
// Purpose: constants and types shared by the board loader and the generation
// engine so that both sides agree on board width and cell indexing
// (cell index = row*GRID_DIM + col).
// Ports: none (package).
package life_pkg;

  localparam int GRID_DIM  = 16;
  localparam int CELLS     = GRID_DIM * GRID_DIM;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = CELLS / BYTE_W;

  typedef logic [CELLS-1:0] board_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } loader_state_e;

endpackage

// File: rtl/board_loader.sv
// rtl/board_loader.sv - assembles a full board from a byte stream, double-buffered
//
// Purpose: bytes are collected in a shadow register; the visible board is only
// updated when the last byte of a frame arrives, so the engine never observes
// a partially written board.
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous active-high reset
//   in_data      BYTE_W cells, in_data[0] is the lowest-indexed cell
//   in_valid     in_data/in_sof valid this cycle
//   in_sof       first byte of a frame (qualified by in_valid)
//   in_ready     byte is accepted this cycle when in_valid is also high
//   hold         engine freeze request, only stalls the input
//   board        last complete board
//   board_valid  one-cycle pulse when board is updated
//   busy         a frame is partially loaded
//   frame_err    one-cycle pulse on a framing error
module board_loader #(
  parameter int CELLS  = life_pkg::CELLS,
  parameter int BYTE_W = life_pkg::BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  input  logic              hold,
  output logic [CELLS-1:0]  board,
  output logic              board_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int NBYTES = CELLS / BYTE_W;
  localparam int CNT_W  = $clog2(NBYTES);

  import life_pkg::*;

  if ((CELLS % BYTE_W) != 0 || NBYTES < 2) begin : g_bad_params
    $error("board_loader: CELLS must be a multiple of BYTE_W and hold at least two bytes");
  end

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CELLS-1:0]  shadow_q, shadow_d;
  logic [CELLS-1:0]  board_q, board_d;
  logic              board_valid_q, board_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              accept;

  assign in_ready    = !reset && !hold && (state_q != COMMIT);
  assign accept      = in_valid && in_ready;
  assign board       = board_q;
  assign board_valid = board_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q == LOAD);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    board_d       = board_q;
    board_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_sof) begin
            shadow_d[BYTE_W-1:0] = in_data;
            cnt_d                = CNT_W'(1);
            state_d              = LOAD;
          end else begin
            // Stray byte outside a frame: dropped and flagged.
            frame_err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (accept) begin
          if (in_sof) begin
            // Restart: the partial frame is abandoned and this byte becomes byte 0.
            // Stale shadow bits are harmless; every byte is rewritten before commit.
            frame_err_d          = 1'b1;
            shadow_d[BYTE_W-1:0] = in_data;
            cnt_d                = CNT_W'(1);
          end else begin
            shadow_d[int'(cnt_q)*BYTE_W +: BYTE_W] = in_data;
            if (cnt_q == CNT_W'(NBYTES - 1)) begin
              // The last byte bypasses the shadow so board loads on the same edge.
              board_d       = {in_data, shadow_q[CELLS-BYTE_W-1:0]};
              board_valid_d = 1'b1;
              cnt_d         = '0;
              state_d       = COMMIT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end

      COMMIT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shadow_q      <= '0;
      board_q       <= '0;
      board_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      board_q       <= board_d;
      board_valid_q <= board_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_board_loader.sv
// tb/tb_board_loader.sv - scoreboard testbench for board_loader
module tb_board_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_sof;
  logic         in_ready;
  logic         hold;
  logic [255:0] board;
  logic         board_valid;
  logic         busy;
  logic         frame_err;

  int compared   = 0;
  int mismatched = 0;
  int fe_count   = 0;
  int bv_count   = 0;
  logic bv_prev  = 1'b0;
  logic [255:0] exp_q[$];
  logic [255:0] last_board = '0;

  board_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .hold       (hold),
    .board      (board),
    .board_valid(board_valid),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected board whenever the DUT pulses board_valid.
  always @(negedge clk) begin
    if (!reset) begin
      if (board_valid) begin
        bv_count++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_board_valid: got pulse expected none");
        end else begin
          last_board = exp_q.pop_front();
          chk("board", board, last_board);
        end
        if (bv_prev) chk("board_valid_single_pulse", 1, 0);
      end
      if (frame_err) fe_count++;
    end
    bv_prev = board_valid;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      hold     = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit sof, input int gap, input bit chk_busy);
    bit acc;
    int tries;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      @(negedge clk);
      in_data  = d;
      in_sof   = sof;
      in_valid = 1'b1;
      hold     = 1'b0;
      #1;
      if (chk_busy && tries == 0) chk("busy_in_frame", busy, 1);
      acc = in_ready;
      @(posedge clk);
      tries++;
    end
    if (!acc) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got no accept expected accept of %0h", d);
    end
  endtask

  // The cycle after the final accept is COMMIT: pulse visible, input stalled.
  task automatic check_commit();
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
    chk("commit_board_valid", board_valid, 1);
    chk("commit_in_ready", in_ready, 0);
    @(negedge clk);
    #1;
    chk("post_commit_in_ready", in_ready, 1);
    chk("post_commit_busy", busy, 0);
  endtask

  function automatic logic [255:0] pack(input logic [7:0] b[32]);
    logic [255:0] r = '0;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = b[k];
    return r;
  endfunction

  initial begin
    logic [7:0] fr[32];
    int fe_base;
    int bv_base;

    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_sof = 1'b0; hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_board", board, 0);
    chk("reset_board_valid", board_valid, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    reset = 1'b0;
    idle(2);

    // 1: byte k = k, no gaps.
    fe_base = fe_count;
    for (int k = 0; k < 32; k++) fr[k] = 8'(k);
    exp_q.push_back(pack(fr));
    for (int k = 0; k < 32; k++) send_byte(fr[k], k == 0, 0, 1'b0);
    check_commit();
    chk("t1_row0_hi", board[15:8], 8'h01);
    chk("t1_row15_hi", board[255:248], 8'h1F);
    chk("t1_no_frame_err", fe_count - fe_base, 0);

    // 2: glider with random gaps; busy checked on every non-first byte.
    for (int k = 0; k < 32; k++) fr[k] = 8'h00;
    fr[0] = 8'h02; fr[2] = 8'h04; fr[4] = 8'h07;
    exp_q.push_back((256'd1 << 1) | (256'd1 << 18) | (256'd7 << 32));
    for (int k = 0; k < 32; k++) send_byte(fr[k], k == 0, int'($urandom_range(0, 2)), k > 0);
    check_commit();

    // 3: in_sof on byte 10 restarts the frame.
    fe_base = fe_count;
    bv_base = bv_count;
    for (int k = 0; k < 10; k++) send_byte(8'hAA, k == 0, 0, 1'b0);
    fr[0] = 8'h11;
    for (int k = 1; k < 32; k++) fr[k] = 8'(8'h20 + k);
    exp_q.push_back(pack(fr));
    send_byte(fr[0], 1'b1, 0, 1'b0);
    for (int k = 1; k < 31; k++) send_byte(fr[k], 1'b0, 0, 1'b1);
    chk("t3_no_early_valid", bv_count - bv_base, 0);
    send_byte(fr[31], 1'b0, 0, 1'b1);
    check_commit();
    chk("t3_frame_err_count", fe_count - fe_base, 1);

    // 4: stray bytes in IDLE.
    fe_base = fe_count;
    for (int k = 0; k < 3; k++) send_byte(8'h5A + 8'(k), 1'b0, 0, 1'b0);
    idle(1);
    #1;
    chk("t4_busy", busy, 0);
    idle(2);
    chk("t4_frame_err_count", fe_count - fe_base, 3);
    chk("t4_board_unchanged", board, last_board);

    // 5: hold for 5 cycles after byte 20.
    for (int k = 0; k < 32; k++) fr[k] = 8'(8'h80 ^ (k * 7));
    exp_q.push_back(pack(fr));
    for (int k = 0; k <= 20; k++) send_byte(fr[k], k == 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      hold = 1'b1;
      #1;
      chk("t5_hold_in_ready", in_ready, 0);
      chk("t5_hold_busy", busy, 1);
    end
    for (int k = 21; k < 32; k++) send_byte(fr[k], 1'b0, 0, 1'b1);
    check_commit();

    // 6: reset mid-frame A, then full frame B.
    bv_base = bv_count;
    for (int k = 0; k <= 15; k++) send_byte(8'hC0 + 8'(k), k == 0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_reset_in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t6_reset_board", board, 0);
    chk("t6_reset_busy", busy, 0);
    for (int k = 0; k < 32; k++) fr[k] = 8'(8'h3C + 3 * k);
    exp_q.push_back(pack(fr));
    for (int k = 0; k < 31; k++) send_byte(fr[k], k == 0, 0, 1'b0);
    idle(1);
    #1;
    chk("t6_board_before_b", board, 0);
    chk("t6_no_valid_for_a", bv_count - bv_base, 0);
    send_byte(fr[31], 1'b0, 0, 1'b0);
    check_commit();

    idle(3);
    chk("queue_drained", exp_q.size(), 0);
    chk("board_valid_total", bv_count, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
